// File: rtl/div_ratio_meter.sv
// Period / high-time meter for a divided clock sampled in the clk domain.
// Define DIV_RATIO_METER_SYNC_EN to put a 2-flop synchronizer in front of clockin.
module div_ratio_meter #(
  parameter int unsigned CW      = 16,
  parameter int unsigned DIV_A   = 4,
  parameter int unsigned DIV_B   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned LOCK_N  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          C1,
  input  logic          clockin,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          match,
  output logic          locked,
  output logic          stall,
  output logic [7:0]    err_cnt
);

  localparam int unsigned   LW         = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CntMax     = '1;
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);
  localparam logic [CW-1:0] ExpA       = CW'(DIV_A);
  localparam logic [CW-1:0] ExpB       = CW'(DIV_B);
  localparam logic [LW-1:0] LockMax    = LW'(LOCK_N);

  typedef enum logic [1:0] {StIdle, StMeas, StStall} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_sig_s, r_sig_d, r_c1_q;
  logic [CW-1:0] r_cnt, r_hcnt, r_period, r_high;
  logic          r_valid, r_match, r_stall;
  logic [7:0]    r_err;
  logic [LW-1:0] r_lock_cnt;

  logic [CW-1:0] w_cnt_nxt, w_hcnt_nxt, w_period_nxt, w_high_nxt, w_exp;
  logic          w_valid_nxt, w_match_nxt, w_stall_nxt;
  logic [7:0]    w_err_nxt;
  logic [LW-1:0] w_lock_nxt;
  logic          w_rise, w_sel_chg, w_timeout;

`ifdef DIV_RATIO_METER_SYNC_EN
  logic r_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 1'b0;
      r_sig_s <= 1'b0;
    end else begin
      r_sync  <= clockin;
      r_sig_s <= r_sync;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sig_s <= 1'b0;
    else      r_sig_s <= clockin;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig_d <= 1'b0;
      r_c1_q  <= 1'b0;
    end else begin
      r_sig_d <= r_sig_s;
      r_c1_q  <= C1;
    end
  end

  assign w_rise    = r_sig_s & ~r_sig_d;
  assign w_sel_chg = (C1 != r_c1_q);
  assign w_exp     = C1 ? ExpA : ExpB;
  assign w_timeout = (r_cnt == TimeoutVal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // A ratio change overrides everything, including a coincident edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_sel_chg) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (w_rise) w_state_nxt = StMeas;
        StMeas:  if (!w_rise && w_timeout) w_state_nxt = StStall;
        StStall: if (w_rise) w_state_nxt = StMeas;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_hcnt_nxt   = r_hcnt;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_valid_nxt  = 1'b0;
    w_match_nxt  = r_match;
    w_stall_nxt  = r_stall;
    w_err_nxt    = r_err;
    w_lock_nxt   = r_lock_cnt;
    if (w_sel_chg) begin
      w_cnt_nxt   = '0;
      w_hcnt_nxt  = '0;
      w_match_nxt = 1'b0;
      w_stall_nxt = 1'b0;
      w_lock_nxt  = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_cnt_nxt  = w_rise ? CW'(1) : '0;
          w_hcnt_nxt = w_rise ? CW'(1) : '0;
        end
        StMeas: begin
          if (w_rise) begin
            w_period_nxt = r_cnt;
            w_high_nxt   = r_hcnt;
            w_valid_nxt  = 1'b1;
            w_match_nxt  = (r_cnt == w_exp);
            if (r_cnt == w_exp) begin
              if (r_lock_cnt != LockMax) w_lock_nxt = r_lock_cnt + 1'b1;
            end else begin
              w_lock_nxt = '0;
              if (r_err != 8'hff) w_err_nxt = r_err + 8'd1;
            end
            w_cnt_nxt  = CW'(1);
            w_hcnt_nxt = CW'(1);
          end else if (w_timeout) begin
            w_stall_nxt = 1'b1;
            w_match_nxt = 1'b0;
            w_lock_nxt  = '0;
          end else begin
            if (r_cnt != CntMax) w_cnt_nxt = r_cnt + 1'b1;
            if (r_sig_s && (r_hcnt != CntMax)) w_hcnt_nxt = r_hcnt + 1'b1;
          end
        end
        StStall: begin
          if (w_rise) begin
            w_cnt_nxt   = CW'(1);
            w_hcnt_nxt  = CW'(1);
            w_stall_nxt = 1'b0;
          end
        end
        default: begin
          w_cnt_nxt  = '0;
          w_hcnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_match    <= 1'b0;
      r_stall    <= 1'b0;
      r_err      <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_period   <= w_period_nxt;
      r_high     <= w_high_nxt;
      r_valid    <= w_valid_nxt;
      r_match    <= w_match_nxt;
      r_stall    <= w_stall_nxt;
      r_err      <= w_err_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign match     = r_match;
  assign locked    = (r_lock_cnt == LockMax);
  assign stall     = r_stall;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Scoreboard bench for div_ratio_meter: stimulus queues expected results,
// a monitor process checks every valid pulse against the queue.
module tb_div_ratio_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        C1 = 1'b1;
  logic        clockin = 1'b0;
  logic [15:0] period, high_time;
  logic        valid, match, locked, stall;
  logic [7:0]  err_cnt;

  div_ratio_meter dut (
    .clk       (clk),
    .rst       (rst),
    .C1        (C1),
    .clockin   (clockin),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .match     (match),
    .locked    (locked),
    .stall     (stall),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
    logic        m;
    logic        l;
    logic [7:0]  e;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_exp, m_act;
  int   n_vec = 0, n_err = 0, n_valid = 0;
  int   cyc = 0, last_valid_cyc = 0;
  int   div = 0, ph = 0;

  always @(posedge clk) cyc++;

  // Divided-clock source: high for the first div/2 clk cycles of each period.
  always @(posedge clk) begin
    #1;
    if (div == 0) begin
      clockin = 1'b0;
    end else begin
      ph = (ph + 1) % div;
      clockin = (ph < div / 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int h, input int m, input int l, input int e);
    exp_t x;
    x.per = p[15:0];
    x.hi  = h[15:0];
    x.m   = m[0];
    x.l   = l[0];
    x.e   = e[7:0];
    exp_q.push_back(x);
  endtask

  task automatic start_div(input int d);
    @(posedge clk);
    #2;
    div = d;
    ph = 0;
    clockin = 1'b1;
  endtask

  task automatic wait_valids(input int target, input int limit);
    int n = 0;
    while (n_valid < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("valid_count", n_valid, target);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_err"}, err_cnt, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        n_vec++;
        m_act = {period, high_time, match, locked, err_cnt};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid #%0d: got p=%0d h=%0d, expected no valid",
                   n_valid, period, high_time);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_act !== m_exp) begin
            n_err++;
            $display("FAIL valid#%0d: got p=%0d h=%0d m=%0d l=%0d e=%0d, expected p=%0d h=%0d m=%0d l=%0d e=%0d",
                     n_valid, m_act.per, m_act.hi, m_act.m, m_act.l, m_act.e,
                     m_exp.per, m_exp.hi, m_exp.m, m_exp.l, m_exp.e);
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);

    // /4 input, C1=1: matches, locks on the 2nd valid
    push(4, 2, 1, 0, 0);
    push(4, 2, 1, 1, 0);
    push(4, 2, 1, 1, 0);
    push(4, 2, 1, 1, 0);
    start_div(4);
    wait_valids(4, 60);
    chk("p1_locked", locked, 1);

    // Expect 8 while /4 keeps running: every period is an error
    C1 = 1'b0;
    push(4, 2, 0, 0, 1);
    push(4, 2, 0, 0, 2);
    push(4, 2, 0, 0, 3);
    wait_valids(7, 60);
    chk("p2_locked", locked, 0);
    chk("p2_err", err_cnt, 3);

    // Ratio toggles mid-period with /8 running: two edges needed before a valid
    push(8, 4, 1, 0, 3);
    push(8, 4, 1, 1, 3);
    C1 = 1'b1;
    start_div(8);
    repeat (3) @(posedge clk);
    #2;
    C1 = 1'b0;
    wait_valids(9, 80);
    chk("p3_err", err_cnt, 3);

    // Stall: input stops, stall exactly TIMEOUT cycles after the last valid
    div = 0;
    clockin = 1'b0;
    n = 0;
    while (!stall && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_seen", stall, 1);
    chk("stall_latency", cyc - last_valid_cyc, 1024);
    chk("stall_period", period, 8);
    chk("stall_high", high_time, 4);
    chk("stall_locked", locked, 0);
    chk("stall_match", match, 0);
    push(8, 4, 1, 0, 3);
    push(8, 4, 1, 1, 3);
    start_div(8);
    n = 0;
    while (stall && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_clear", stall, 0);
    wait_valids(11, 80);

    // Reset mid-measurement
    rst = 1'b0;
    div = 0;
    clockin = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    push(8, 4, 1, 0, 0);
    push(8, 4, 1, 1, 0);
    start_div(8);
    wait_valids(13, 80);

    // Error counter saturation
    rst = 1'b0;
    div = 0;
    clockin = 1'b0;
    #1;
    chk("sat_rst_err", err_cnt, 0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 1; i <= 270; i++) push(4, 2, 0, 0, (i > 255) ? 255 : i);
    start_div(4);
    wait_valids(283, 1300);
    div = 0;
    clockin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("sat_err", err_cnt, 255);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
